fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single async-FIFO write port (REF_CLK domain) between several response producers: register-file read data, 16-bit ALU results and error/status bytes.
- Arbitrates round-robin between requesters and serializes each accepted response into one or two bytes.
- Paces writes against FIFO full and drives the FIFO write data and write-increment pins directly.
- Sits between the system controller's response sources and the async FIFO write side.

Parameters:
- DATA_WIDTH, 8: FIFO byte width.
- NUM_REQ, 3: number of requesters; requester index 0 has top priority out of reset.
- RESP_WIDTH, 2*DATA_WIDTH: width of each requester's response word.

Ports:
- CLK  input  1  REF_CLK-domain clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  NUM_REQ  per-requester response pending.
- REQ_DATA  input  NUM_REQ*RESP_WIDTH  packed response words; requester i occupies bits [i*RESP_WIDTH +: RESP_WIDTH].
- REQ_TWO_BYTE  input  NUM_REQ  1 = send both bytes of the word; 0 = send the low byte only.
- REQ_READY  output  NUM_REQ  one-hot accept strobe.
- FIFO_FULL  input  1  write-side full flag from the async FIFO.
- FIFO_WR_DATA  output  DATA_WIDTH  byte presented to the FIFO.
- FIFO_WR_INC  output  1  FIFO write strobe; one byte is written per cycle in which it is high.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, SEND_LO, SEND_HI.

IDLE:
- Winner = first requester with REQ_VALID=1, searching from rr_ptr upward modulo NUM_REQ.
- REQ_READY[winner] is combinational, high only in IDLE and only when RST=0.
- Handshake = REQ_VALID & REQ_READY.
- On a handshake, at the clock edge:
  - hold_word <= REQ_DATA[winner]
  - hold_two <= REQ_TWO_BYTE[winner]
  - rr_ptr <= (winner+1) mod NUM_REQ
  - state -> SEND_LO
- With no valid requester: stay in IDLE; rr_ptr unchanged.

SEND_LO:
- FIFO_WR_DATA = hold_word[DATA_WIDTH-1:0].
- FIFO_WR_INC = !FIFO_FULL (combinational, so full is checked in the same cycle the write is issued).
- If FIFO_FULL=1: hold state; no write is lost or duplicated.
- If FIFO_FULL=0: go to SEND_HI when hold_two=1, else to IDLE.

SEND_HI:
- FIFO_WR_DATA = hold_word[RESP_WIDTH-1:DATA_WIDTH].
- FIFO_WR_INC = !FIFO_FULL.
- Go to IDLE when FIFO_FULL=0.

Byte order and throughput:
- Low byte is always sent first.
- Minimum spacing is one write per cycle inside a response.
- There is one IDLE arbitration cycle between responses, so the peak rate is 2 bytes per 3 cycles.

Requester rules:
- Requesters hold REQ_VALID and REQ_DATA stable until they see REQ_READY.
- A requester may drop REQ_VALID before it is accepted; nothing is latched for it.
- REQ_VALID seen during SEND_LO/SEND_HI is ignored: REQ_READY stays low and the request waits.

Outputs in IDLE:
- FIFO_WR_INC=0.
- FIFO_WR_DATA = low byte of hold_word (don't-care for the FIFO, but deterministic).

Reset (RST=1 at a clock edge):
- state=IDLE, rr_ptr=0, hold_word=0, hold_two=0.
- While RST=1, FIFO_WR_INC, REQ_READY and BUSY are forced 0.
- A response in flight is abandoned; a partially sent response stays partial in the FIFO.

NUM_REQ=1 degenerates to a plain serializer; rr_ptr stays 0.

Decomposition:
- Shared package fifo_wr_arb_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_SEND_LO=2'd1, ST_SEND_HI=2'd2.
  - Requester index constants REQ_RF=0, REQ_ALU=1, REQ_STAT=2.
- Sub-module rr_arbiter (NUM_REQ):
  - Purely combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, binary winner index, any_req.
- The parent owns rr_ptr, the FSM, the hold registers and the FIFO drive.

Test Plan:
- Single one-byte request: REQ_VALID=3'b001, REQ_DATA[0]=16'h00A5, TWO_BYTE=0, FIFO_FULL=0.
  Expect REQ_READY=001 for one cycle, then exactly one FIFO_WR_INC with data 8'hA5, then IDLE.
- ALU two-byte request: req1 data 16'hBEEF, TWO_BYTE=1.
  Expect FIFO writes 8'hEF then 8'hBE on consecutive cycles, BUSY high for 2 cycles.
- Round robin: all three requesters valid continuously, each with a unique word.
  Expect accepts in order 0,1,2,0,1,2; no requester is granted twice before the others are served.
- Backpressure: FIFO_FULL=1 for 5 cycles while in SEND_HI with 16'h1234.
  Expect no FIFO_WR_INC during those cycles and data held at 8'h12; exactly one write after FULL drops.
  Expect total FIFO writes = 2 (8'h34, 8'h12).
- Reset mid-response: assert RST in the cycle after the 8'hEF write of 16'hBEEF.
  Expect no further write; state returns to IDLE and rr_ptr to 0.
  Expect the next request from requester 0 to be granted first even if requester 1 is also valid.
- Request during send: req2 raises valid while SEND_LO is stalled by FIFO_FULL.
  Expect REQ_READY[2]=0 until the current response completes, then req2 accepted next in IDLE.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared encodings for the FIFO write-port arbiter.
// Requester indices match the system controller's response sources.
package fifo_wr_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND_LO = 2'd1;
   localparam logic [1:0] ST_SEND_HI = 2'd2;

   localparam int REQ_RF   = 0;
   localparam int REQ_ALU  = 1;
   localparam int REQ_STAT = 2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      SEND_LO = ST_SEND_LO,
      SEND_HI = ST_SEND_HI
   } state_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: first set request
// at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   winner,
   output logic               any_req
);

   logic found;

   always_comb begin
      grant   = '0;
      winner  = '0;
      found   = 1'b0;
      any_req = |req;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx[PTR_W-1:0]]) begin
            found                     = 1'b1;
            winner                    = idx[PTR_W-1:0];
            grant[idx[PTR_W-1:0]]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of the async FIFO write port; each
// accepted response goes out low byte first, paced by full.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 3,
   parameter int RESP_WIDTH = 2 * DATA_WIDTH
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   input  logic [NUM_REQ*RESP_WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]            REQ_TWO_BYTE,
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic                          FIFO_FULL,
   output logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
   output logic                          FIFO_WR_INC,
   output logic                          BUSY
);

   localparam int PTR_W = ptr_w(NUM_REQ);

   state_t                  state;
   logic [PTR_W-1:0]        rr_ptr;
   logic [RESP_WIDTH-1:0]   hold_word;
   logic                    hold_two;

   logic [RESP_WIDTH-1:0]   req_word [NUM_REQ];
   logic [NUM_REQ-1:0]      grant;
   logic [PTR_W-1:0]        winner;
   logic                    any_req;
   logic                    in_idle;
   logic                    accept;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
      assign req_word[i] = REQ_DATA[i*RESP_WIDTH +: RESP_WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req     (REQ_VALID),
      .rr_ptr  (rr_ptr),
      .grant   (grant),
      .winner  (winner),
      .any_req (any_req)
   );

   assign in_idle   = (state == IDLE);
   assign accept    = in_idle && any_req && !RST;
   assign REQ_READY = accept ? grant : '0;
   assign BUSY      = !in_idle && !RST;

   // Full is checked in the issuing cycle, so a stalled
   // byte is simply re-presented until it lands.
   assign FIFO_WR_INC  = BUSY && !FIFO_FULL;
   assign FIFO_WR_DATA = (state == SEND_HI)
                       ? hold_word[RESP_WIDTH-1:DATA_WIDTH]
                       : hold_word[DATA_WIDTH-1:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         rr_ptr    <= PTR_W'(REQ_RF);
         hold_word <= '0;
         hold_two  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  hold_word <= req_word[winner];
                  hold_two  <= REQ_TWO_BYTE[winner];
                  rr_ptr    <= (int'(winner) == NUM_REQ - 1)
                             ? '0 : winner + 1'b1;
                  state     <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (!FIFO_FULL)
                  state <= hold_two ? SEND_HI : IDLE;
            end
            SEND_HI: begin
               if (!FIFO_FULL)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed checks for fifo_wr_arbiter: serialization,
// round robin, backpressure, reset abort, late requests.
module tb_fifo_wr_arbiter;
   import fifo_wr_arb_pkg::*;

   localparam int DW = 8;
   localparam int NR = 3;
   localparam int RW = 16;

   logic            CLK = 1'b0;
   logic            RST;
   logic [NR-1:0]   REQ_VALID;
   logic [NR*RW-1:0] REQ_DATA;
   logic [NR-1:0]   REQ_TWO_BYTE;
   logic [NR-1:0]   REQ_READY;
   logic            FIFO_FULL;
   logic [DW-1:0]   FIFO_WR_DATA;
   logic            FIFO_WR_INC;
   logic            BUSY;

   int n_chk = 0;
   int n_bad = 0;
   logic [7:0] wq[$];
   int         aq[$];

   always #5 CLK = ~CLK;

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .RESP_WIDTH (RW)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ_VALID    (REQ_VALID),
      .REQ_DATA     (REQ_DATA),
      .REQ_TWO_BYTE (REQ_TWO_BYTE),
      .REQ_READY    (REQ_READY),
      .FIFO_FULL    (FIFO_FULL),
      .FIFO_WR_DATA (FIFO_WR_DATA),
      .FIFO_WR_INC  (FIFO_WR_INC),
      .BUSY         (BUSY)
   );

   always @(negedge CLK) begin
      if (!RST) begin
         if (FIFO_WR_INC) wq.push_back(FIFO_WR_DATA);
         for (int i = 0; i < NR; i++)
            if (REQ_READY[i]) aq.push_back(i);
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic neg();
      @(negedge CLK);
   endtask

   function automatic logic [7:0] wq_at(input int i);
      return (i < wq.size()) ? wq[i] : 8'hxx;
   endfunction

   function automatic int aq_at(input int i);
      return (i < aq.size()) ? aq[i] : -1;
   endfunction

   initial begin
      RST          = 1'b1;
      REQ_VALID    = 3'b111;
      REQ_DATA     = '0;
      REQ_TWO_BYTE = '0;
      FIFO_FULL    = 1'b0;

      // reset: outputs forced low even with valid requests
      neg();
      chk("rst_ready", REQ_READY, 3'b000);
      chk("rst_inc", FIFO_WR_INC, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      tick();
      tick();
      REQ_VALID = '0;
      RST       = 1'b0;
      neg();
      chk("idle_busy", BUSY, 1'b0);
      chk("idle_inc", FIFO_WR_INC, 1'b0);
      chk("idle_data", FIFO_WR_DATA, 8'h00);
      tick();

      // single one-byte request from requester 0
      wq.delete();
      REQ_DATA[0*RW +: RW] = 16'h00A5;
      REQ_TWO_BYTE         = 3'b000;
      REQ_VALID            = 3'b001;
      neg();
      chk("t1_ready", REQ_READY, 3'b001);
      tick();
      REQ_VALID = '0;
      neg();
      chk("t1_ready_lo", REQ_READY, 3'b000);
      chk("t1_busy", BUSY, 1'b1);
      chk("t1_inc", FIFO_WR_INC, 1'b1);
      chk("t1_data", FIFO_WR_DATA, 8'hA5);
      tick();
      neg();
      chk("t1_idle", BUSY, 1'b0);
      chk("t1_inc_end", FIFO_WR_INC, 1'b0);
      tick();
      chk("t1_nwr", wq.size(), 1);
      chk("t1_wr0", wq_at(0), 8'hA5);

      // two-byte ALU response
      wq.delete();
      REQ_DATA[REQ_ALU*RW +: RW] = 16'hBEEF;
      REQ_TWO_BYTE = 3'b010;
      REQ_VALID    = 3'b010;
      neg();
      chk("t2_ready", REQ_READY, 3'b010);
      tick();
      REQ_VALID = '0;
      neg();
      chk("t2_busy0", BUSY, 1'b1);
      chk("t2_inc0", FIFO_WR_INC, 1'b1);
      chk("t2_lo", FIFO_WR_DATA, 8'hEF);
      tick();
      neg();
      chk("t2_busy1", BUSY, 1'b1);
      chk("t2_inc1", FIFO_WR_INC, 1'b1);
      chk("t2_hi", FIFO_WR_DATA, 8'hBE);
      tick();
      neg();
      chk("t2_idle", BUSY, 1'b0);
      tick();
      chk("t2_nwr", wq.size(), 2);

      // round robin from a fresh pointer
      RST = 1'b1;
      tick();
      RST = 1'b0;
      wq.delete();
      aq.delete();
      REQ_DATA     = {16'h0033, 16'h0022, 16'h0011};
      REQ_TWO_BYTE = 3'b000;
      REQ_VALID    = 3'b111;
      for (int c = 0; c < 40 && aq.size() < 6; c++) tick();
      REQ_VALID = '0;
      tick();
      tick();
      chk("rr_nacc", aq.size(), 6);
      chk("rr_nwr", wq.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_acc%0d", i), aq_at(i), i % 3);
         chk($sformatf("rr_wr%0d", i), wq_at(i),
             8'h11 * ((i % 3) + 1));
      end

      // backpressure in SEND_HI (pointer back at 0)
      wq.delete();
      REQ_DATA[REQ_RF*RW +: RW] = 16'h1234;
      REQ_TWO_BYTE = 3'b001;
      REQ_VALID    = 3'b001;
      neg();
      chk("bp_ready", REQ_READY, 3'b001);
      tick();
      REQ_VALID = '0;
      neg();
      chk("bp_lo", FIFO_WR_DATA, 8'h34);
      tick();
      FIFO_FULL = 1'b1;
      for (int c = 0; c < 5; c++) begin
         neg();
         chk($sformatf("bp_inc%0d", c), FIFO_WR_INC, 1'b0);
         chk($sformatf("bp_hold%0d", c), FIFO_WR_DATA, 8'h12);
         chk($sformatf("bp_busy%0d", c), BUSY, 1'b1);
         tick();
      end
      FIFO_FULL = 1'b0;
      neg();
      chk("bp_inc_go", FIFO_WR_INC, 1'b1);
      chk("bp_hi", FIFO_WR_DATA, 8'h12);
      tick();
      neg();
      chk("bp_idle", BUSY, 1'b0);
      tick();
      chk("bp_nwr", wq.size(), 2);
      chk("bp_wr0", wq_at(0), 8'h34);
      chk("bp_wr1", wq_at(1), 8'h12);

      // reset after the low byte of 16'hBEEF (pointer at 1)
      wq.delete();
      REQ_DATA[REQ_ALU*RW +: RW] = 16'hBEEF;
      REQ_TWO_BYTE = 3'b010;
      REQ_VALID    = 3'b010;
      neg();
      chk("ra_ready", REQ_READY, 3'b010);
      tick();
      REQ_VALID = '0;
      neg();
      chk("ra_lo", FIFO_WR_DATA, 8'hEF);
      tick();
      RST = 1'b1;
      neg();
      chk("ra_inc", FIFO_WR_INC, 1'b0);
      chk("ra_busy", BUSY, 1'b0);
      tick();
      RST = 1'b0;
      REQ_DATA[REQ_RF*RW +: RW] = 16'h0055;
      REQ_TWO_BYTE = 3'b010;
      REQ_VALID    = 3'b011;
      neg();
      chk("ra_ptr0", REQ_READY, 3'b001);
      chk("ra_busy_idle", BUSY, 1'b0);
      tick();
      REQ_VALID = '0;
      neg();
      chk("ra_wr", FIFO_WR_DATA, 8'h55);
      tick();
      tick();
      chk("ra_nwr", wq.size(), 2);
      chk("ra_wr0", wq_at(0), 8'hEF);
      chk("ra_wr1", wq_at(1), 8'h55);

      // late request while SEND_LO is stalled (pointer at 1)
      wq.delete();
      aq.delete();
      REQ_DATA[REQ_RF*RW +: RW]   = 16'h00C3;
      REQ_DATA[REQ_STAT*RW +: RW] = 16'h0077;
      REQ_TWO_BYTE = 3'b000;
      REQ_VALID    = 3'b001;
      tick();
      REQ_VALID = 3'b100;
      FIFO_FULL = 1'b1;
      for (int c = 0; c < 3; c++) begin
         neg();
         chk($sformatf("ld_rdy%0d", c), REQ_READY, 3'b000);
         chk($sformatf("ld_inc%0d", c), FIFO_WR_INC, 1'b0);
         tick();
      end
      FIFO_FULL = 1'b0;
      neg();
      chk("ld_rdy_go", REQ_READY, 3'b000);
      chk("ld_lo", FIFO_WR_DATA, 8'hC3);
      tick();
      neg();
      chk("ld_acc2", REQ_READY, 3'b100);
      tick();
      REQ_VALID = '0;
      neg();
      chk("ld_wr2", FIFO_WR_DATA, 8'h77);
      tick();
      neg();
      chk("ld_idle", BUSY, 1'b0);
      tick();
      chk("ld_nwr", wq.size(), 2);
      chk("ld_wr0", wq_at(0), 8'hC3);
      chk("ld_wr1", wq_at(1), 8'h77);
      chk("ld_nacc", aq.size(), 2);
      chk("ld_acc_order", aq_at(1), REQ_STAT);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
